// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, port IDs and
// the default word width shared with the core.
package mem_responder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int WORD_LEN_DEF = 32;

endpackage

// File: rtl/mem_responder_rr_arb2.sv
// Two-requester round-robin arbiter. Grants at most one port per cycle and
// remembers the last granted port to alternate under contention.
module rr_arb2
    import mem_responder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    logic last_grant_q;
    logic last_grant_d;

    // Under contention the port that did not win last time goes first.
    always_comb begin
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        last_grant_d = last_grant_q;
        if (en) begin
            gnt_d = req_d && (!req_i || (last_grant_q == PORT_I));
            gnt_i = req_i && (!req_d || (last_grant_q == PORT_D));
            if (gnt_d) begin
                last_grant_d = PORT_D;
            end else if (gnt_i) begin
                last_grant_d = PORT_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates instruction and data requests onto one
// single-ported word RAM and answers each after a fixed LATENCY.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    WORD_LEN  = WORD_LEN_DEF,
    parameter int    DEPTH_BIT = 14,
    parameter int    LATENCY   = 2,
    parameter string MEM_FILE  = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam int CNT_W = 4;

    logic [WORD_LEN-1:0] mem [DEPTH];

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 port_q, port_d;
    logic [DEPTH_BIT-1:0] idx_q, idx_d;
    logic                 wen_q, wen_d;
    logic [WORD_LEN-1:0]  wdata_q, wdata_d;
    logic                 i_rvalid_q, i_rvalid_d;
    logic                 d_rvalid_q, d_rvalid_d;
    logic [WORD_LEN-1:0]  i_rdata_q, i_rdata_d;
    logic [WORD_LEN-1:0]  d_rdata_q, d_rdata_d;

    logic                 gnt_i, gnt_d, accept;
    logic                 acc_port, acc_wen;
    logic [DEPTH_BIT-1:0] acc_idx;
    logic                 mem_en, mem_port, mem_wen;
    logic [DEPTH_BIT-1:0] mem_idx;
    logic [WORD_LEN-1:0]  mem_wdata, rd_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[WORD_LEN-1:DEPTH_BIT+2], i_addr[1:0],
                                d_addr[WORD_LEN-1:DEPTH_BIT+2], d_addr[1:0]};

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = '0;
        end
    end

    // Ready is gated by reset so nothing can be accepted while held in reset.
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state_q == ST_IDLE) && rst_n),
        .req_i (i_valid),
        .req_d (d_valid),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    assign i_ready  = gnt_i;
    assign d_ready  = gnt_d;
    assign accept   = gnt_i || gnt_d;
    assign acc_port = gnt_d ? PORT_D : PORT_I;
    assign acc_idx  = gnt_d ? d_addr[DEPTH_BIT+1:2] : i_addr[DEPTH_BIT+1:2];
    assign acc_wen  = gnt_d && d_wen;

    // With LATENCY==1 the access happens on the accept edge itself so the
    // responder can stream one request per cycle; otherwise it waits in BUSY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        idx_d     = idx_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        mem_en    = 1'b0;
        mem_port  = port_q;
        mem_idx   = idx_q;
        mem_wen   = wen_q;
        mem_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    port_d  = acc_port;
                    idx_d   = acc_idx;
                    wen_d   = acc_wen;
                    wdata_d = d_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        mem_en    = 1'b1;
                        mem_port  = acc_port;
                        mem_idx   = acc_idx;
                        mem_wen   = acc_wen;
                        mem_wdata = d_wdata;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mem_en  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        rd_word    = mem[mem_idx];
        if (mem_en) begin
            if (mem_port == PORT_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = mem_wen ? '0 : rd_word;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = rd_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_I;
            idx_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            idx_q      <= idx_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_en && mem_wen) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers push expected responses,
// per-port monitors pop and compare data and arrival cycle.
module tb_mem_responder;

    localparam int L0 = 2;
    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_valid, i_ready, i_rvalid, d_valid, d_ready, d_wen, d_rvalid;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic        i_valid1, i_ready1, i_rvalid1, d_valid1, d_ready1, d_wen1, d_rvalid1;
    logic [31:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1;

    mem_responder #(.WORD_LEN(32), .DEPTH_BIT(4), .LATENCY(L0), .MEM_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata)
    );

    mem_responder #(.WORD_LEN(32), .DEPTH_BIT(6), .LATENCY(L1), .MEM_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid1), .i_ready(i_ready1), .i_addr(i_addr1),
        .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_valid(d_valid1), .d_ready(d_ready1), .d_addr(d_addr1), .d_wen(d_wen1),
        .d_wdata(d_wdata1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qi[$], qd[$], qi1[$], qd1[$];
    logic gq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: rvalid with no response expected", name);
    endtask

    exp_t ei, ed, ei1, ed1;

    always @(negedge clk) begin
        if (i_rvalid === 1'b1) begin
            if (qi.size() == 0) unexpected("i_rvalid");
            else begin
                ei = qi.pop_front();
                check("i_rdata", i_rdata, ei.data);
                check("i_latency", cyc, ei.cyc);
            end
        end
        if (d_rvalid === 1'b1) begin
            if (qd.size() == 0) unexpected("d_rvalid");
            else begin
                ed = qd.pop_front();
                check("d_rdata", d_rdata, ed.data);
                check("d_latency", cyc, ed.cyc);
            end
        end
        if (i_rvalid1 === 1'b1) begin
            if (qi1.size() == 0) unexpected("i_rvalid1");
            else begin
                ei1 = qi1.pop_front();
                check("i_rdata1", i_rdata1, ei1.data);
                check("i_latency1", cyc, ei1.cyc);
            end
        end
        if (d_rvalid1 === 1'b1) begin
            if (qd1.size() == 0) unexpected("d_rvalid1");
            else begin
                ed1 = qd1.pop_front();
                check("d_rdata1", d_rdata1, ed1.data);
                check("d_latency1", cyc, ed1.cyc);
            end
        end
    end

    task automatic i_req(input logic [31:0] addr, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_addr  = addr;
        #1;
        while (i_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) unexpected("i_ready_timeout");
        else begin
            qi.push_back('{exp, cyc + L0});
            gq.push_back(1'b0);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic d_req(input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        d_valid = 1'b1;
        d_addr  = addr;
        d_wen   = wen;
        d_wdata = wdata;
        #1;
        while (d_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) unexpected("d_ready_timeout");
        else begin
            qd.push_back('{exp, cyc + L0});
            gq.push_back(1'b1);
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic i1_req(input logic [31:0] addr, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        i_valid1 = 1'b1;
        i_addr1  = addr;
        #1;
        while (i_ready1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) unexpected("i1_ready_timeout");
        else qi1.push_back('{exp, cyc + L1});
        @(posedge clk);
        #1;
        i_valid1 = 1'b0;
    endtask

    task automatic d1_req(input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        d_valid1 = 1'b1;
        d_addr1  = addr;
        d_wen1   = wen;
        d_wdata1 = wdata;
        #1;
        while (d_ready1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) unexpected("d1_ready_timeout");
        else qd1.push_back('{exp, cyc + L1});
        @(posedge clk);
        #1;
        d_valid1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qi.size() + qd.size() + qi1.size() + qd1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_i_ready"},  {31'd0, i_ready},  32'd0);
        check({tag, "_d_ready"},  {31'd0, d_ready},  32'd0);
        check({tag, "_i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
        check({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
        check({tag, "_i_rdata"},  i_rdata,           32'd0);
        check({tag, "_d_rdata"},  d_rdata,           32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic exp_grant [4];
        exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n    = 1'b0;
        i_valid  = 1'b1; i_addr  = 32'h0; d_valid  = 1'b1; d_addr  = 32'h0;
        d_wen    = 1'b1; d_wdata = 32'hFFFF_FFFF;
        i_valid1 = 1'b0; i_addr1 = 32'h0; d_valid1 = 1'b0; d_addr1 = 32'h0;
        d_wen1   = 1'b0; d_wdata1 = 32'h0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        i_valid = 1'b0;
        d_valid = 1'b0;
        rst_n   = 1'b1;

        $display("[TB] contention: D and I both requesting from reset");
        fork
            begin
                d_req(32'h20, 1'b1, 32'h1111_1111, 32'h0);
                d_req(32'h24, 1'b1, 32'h2222_2222, 32'h0);
            end
            begin
                i_req(32'h20, 32'h1111_1111);
                i_req(32'h24, 32'h2222_2222);
            end
        join
        drain();
        check("grant_count", gq.size(), 4);
        for (int k = 0; k < 4 && k < gq.size(); k++) begin
            check($sformatf("grant_order_%0d", k), {31'd0, gq[k]}, {31'd0, exp_grant[k]});
        end
        gq.delete();

        $display("[TB] single fetch of preloaded word");
        d_req(32'h0C, 1'b1, 32'hDEAD_BEEF, 32'h0);
        drain();
        i_req(32'h0C, 32'hDEAD_BEEF);
        drain();

        $display("[TB] write then read, then address wrap");
        d_req(32'h40, 1'b1, 32'h1234_5678, 32'h0);
        d_req(32'h40, 1'b0, 32'h0, 32'h1234_5678);
        d_req(32'h40, 1'b1, 32'hA5A5_A5A5, 32'h0);
        i_req(32'h00, 32'hA5A5_A5A5);
        d_req(32'h41, 1'b0, 32'h0, 32'hA5A5_A5A5);
        drain();

        $display("[TB] reset while a write is in flight");
        d_req(32'h10, 1'b1, 32'h5555_AAAA, 32'h0);
        drain();
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h10; d_wen = 1'b1; d_wdata = 32'hFFFF_FFFF;
        #1;
        check("midop_accept", {31'd0, d_ready}, 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midop");
        repeat (2) @(negedge clk);
        i_valid = 1'b0;
        d_valid = 1'b0;
        rst_n   = 1'b1;
        repeat (4) @(negedge clk);
        d_req(32'h10, 1'b0, 32'h0, 32'h5555_AAAA);
        drain();

        $display("[TB] LATENCY=1 streaming fetch");
        for (int k = 0; k < 8; k++) begin
            d1_req(32'(k * 4), 1'b1, 32'hC0DE_0000 + 32'(k), 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            i1_req(32'(k * 4), 32'hC0DE_0000 + 32'(k));
        end
        drain();

        check("queues_empty", qi.size() + qd.size() + qi1.size() + qd1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
